// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: sweeps every RAM entry with a fixed pattern after
// resetRams_i, then hands the RAM write port to the functional path.
module ram_init_ctrl #(
    parameter int DEPTH     = 32,
    parameter int INDEX     = 5,
    parameter int WIDTH     = 8,
    parameter int INIT_MODE = 0,
    parameter int INIT_BASE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resetRams_i,
    input  logic             we_i,
    input  logic [INDEX-1:0] addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ram_we_o,
    output logic [INDEX-1:0] ram_addr_o,
    output logic [WIDTH-1:0] ram_data_o,
    output logic             ramReady_o,
    output logic             initBusy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [INDEX-1:0] LAST_ADDR = INDEX'(DEPTH - 1);
    localparam logic [WIDTH-1:0] BASE_W    = WIDTH'(INIT_BASE);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [INDEX-1:0] r_cnt;
    logic [INDEX-1:0] w_cnt_nxt;
    logic             r_ready;
    logic [WIDTH-1:0] w_init_data;

    // Init pattern: zero, or address plus base wrapping at WIDTH bits.
    always_comb begin
        w_init_data = '0;
        if (INIT_MODE == 1) begin
            w_init_data = WIDTH'(r_cnt) + BASE_W;
        end
    end

    // State, sweep counter and registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == S_READY);
        end
    end

    // Next state, counter and RAM port mux; resetRams_i overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = '0;
        case (r_state)
            S_IDLE: begin
            end
            S_INIT: begin
                ram_we_o   = 1'b1;
                ram_addr_o = r_cnt;
                ram_data_o = w_init_data;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = S_READY;
                end else begin
                    w_cnt_nxt = r_cnt + INDEX'(1);
                end
            end
            S_READY: begin
                ram_we_o   = we_i;
                ram_addr_o = addr_i;
                ram_data_o = data_i;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (resetRams_i) begin
            w_state_nxt = S_INIT;
            w_cnt_nxt   = '0;
        end
    end

    assign ramReady_o = r_ready;
    assign initBusy_o = (r_state == S_INIT);

endmodule

// File: tb/tb_ram_init_ctrl.sv
// Directed bench for ram_init_ctrl: one zero-fill instance plus two
// address+base instances (with and without data wrap) on shared stimulus.
module tb_ram_init_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       resetRams;
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;

    logic       a_we, a_rdy, a_busy;
    logic [4:0] a_addr;
    logic [7:0] a_data;
    logic       b_we, b_rdy, b_busy;
    logic [4:0] b_addr;
    logic [3:0] b_data;
    logic       c_we, c_rdy, c_busy;
    logic [4:0] c_addr;
    logic [3:0] c_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_init_ctrl #(.DEPTH(8), .INDEX(5), .WIDTH(8), .INIT_MODE(0), .INIT_BASE(0)) u_a (
        .clk(clk), .reset(reset), .resetRams_i(resetRams), .we_i(we), .addr_i(addr),
        .data_i(data), .ram_we_o(a_we), .ram_addr_o(a_addr), .ram_data_o(a_data),
        .ramReady_o(a_rdy), .initBusy_o(a_busy));

    ram_init_ctrl #(.DEPTH(8), .INDEX(5), .WIDTH(4), .INIT_MODE(1), .INIT_BASE(8)) u_b (
        .clk(clk), .reset(reset), .resetRams_i(resetRams), .we_i(we), .addr_i(addr),
        .data_i(data[3:0]), .ram_we_o(b_we), .ram_addr_o(b_addr), .ram_data_o(b_data),
        .ramReady_o(b_rdy), .initBusy_o(b_busy));

    ram_init_ctrl #(.DEPTH(8), .INDEX(5), .WIDTH(4), .INIT_MODE(1), .INIT_BASE(12)) u_c (
        .clk(clk), .reset(reset), .resetRams_i(resetRams), .we_i(we), .addr_i(addr),
        .data_i(data[3:0]), .ram_we_o(c_we), .ram_addr_o(c_addr), .ram_data_o(c_data),
        .ramReady_o(c_rdy), .initBusy_o(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge and let combinational outputs settle.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Check instance A's port in one go.
    task automatic chk_a(input string tag, input logic we_e, input logic [4:0] ad_e,
                         input logic [7:0] d_e, input logic rdy_e, input logic busy_e);
        chk({tag, ".we"},   32'(a_we),   32'(we_e));
        chk({tag, ".addr"}, 32'(a_addr), 32'(ad_e));
        chk({tag, ".data"}, 32'(a_data), 32'(d_e));
        chk({tag, ".rdy"},  32'(a_rdy),  32'(rdy_e));
        chk({tag, ".busy"}, 32'(a_busy), 32'(busy_e));
    endtask

    initial begin
        reset = 1'b1; resetRams = 1'b0; we = 1'b0; addr = '0; data = '0;
        cyc(); cyc();
        chk_a("reset", 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        chk("reset.b_rdy", 32'(b_rdy), 32'd0);

        // IDLE drops functional writes.
        reset = 1'b0; we = 1'b1; addr = 5'd3; data = 8'hA5;
        cyc();
        chk_a("idle_drop", 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        cyc();
        chk("idle_drop2.we", 32'(a_we), 32'd0);

        // One-cycle pulse; functional stimulus stays applied and must be ignored.
        resetRams = 1'b1;
        cyc();
        resetRams = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_a($sformatf("sweep0_%0d", k), 1'b1, 5'(k), 8'd0, 1'b0, 1'b1);
            chk($sformatf("sweepB_%0d", k), 32'(b_data), 32'(8 + k));
            chk($sformatf("sweepC_%0d", k), 32'(c_data), 32'((12 + k) % 16));
            chk($sformatf("sweepC_we_%0d", k), 32'(c_we), 32'd1);
            cyc();
        end
        // READY: functional path passes through in the same cycle.
        chk_a("ready_pass", 1'b1, 5'd3, 8'hA5, 1'b1, 1'b0);
        chk("ready_pass.b_rdy", 32'(b_rdy), 32'd1);
        chk("ready_pass.b_data", 32'(b_data), 32'h5);
        we = 1'b0; addr = 5'd9; data = 8'h3C;
        #1;
        chk_a("ready_nowe", 1'b0, 5'd9, 8'h3C, 1'b1, 1'b0);

        // Restart from READY, then restart again at the addr-4 write.
        resetRams = 1'b1;
        cyc();
        resetRams = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk_a($sformatf("rs1_%0d", k), 1'b1, 5'(k), 8'd0, 1'b0, 1'b1);
            if (k == 4) resetRams = 1'b1;
            cyc();
        end
        resetRams = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_a($sformatf("rs2_%0d", k), 1'b1, 5'(k), 8'd0, 1'b0, 1'b1);
            cyc();
        end
        chk_a("rs2_done", 1'b0, 5'd9, 8'h3C, 1'b1, 1'b0);

        // resetRams held high for five cycles pins the sweep at address 0.
        resetRams = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk_a($sformatf("hold_%0d", i), 1'b1, 5'd0, 8'd0, 1'b0, 1'b1);
        end
        resetRams = 1'b0;
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk_a($sformatf("hold_sw_%0d", k), 1'b1, 5'(k), 8'd0, 1'b0, 1'b1);
        end
        cyc();
        chk("hold_done.rdy", 32'(a_rdy), 32'd1);

        // Reset at the addr-5 write aborts to IDLE.
        resetRams = 1'b1;
        cyc();
        resetRams = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk_a($sformatf("abort_%0d", k), 1'b1, 5'(k), 8'd0, 1'b0, 1'b1);
            if (k < 5) cyc();
        end
        reset = 1'b1;
        cyc();
        chk_a("abort_idle", 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        // reset wins over resetRams.
        resetRams = 1'b1; we = 1'b1;
        cyc();
        chk_a("both_high", 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        reset = 1'b0; resetRams = 1'b0;
        cyc();
        chk_a("post_abort", 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        cyc();
        chk("post_abort2.we", 32'(a_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
